// File: rtl/hash_target_cmp.sv
`default_nettype none
// ============================================================================
// Module   : hash_target_cmp
// Purpose  : Captures a 256-bit digest once the upstream serial-to-parallel
//            register has been filled, compares it with the difficulty
//            target one word per cycle (most significant word first), and
//            reports hash_found plus the matching nonce over valid/ready.
// Options  : HASH_CMP_EARLY_EXIT_EN - leave COMPARE as soon as the first
//            differing word decides the outcome.
// Revision : 1.0 - initial release
// ============================================================================
module hash_target_cmp #(
    parameter int NUM_WORDS = 8,
    parameter int WORD_W    = 32
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        shift_enable,
    input  logic [NUM_WORDS*WORD_W-1:0] parallel_in,
    input  logic [NUM_WORDS*WORD_W-1:0] target,
    input  logic [31:0]                 nonce,
    input  logic                        result_ready,
    output logic                        result_valid,
    output logic                        hash_found,
    output logic [31:0]                 found_nonce,
    output logic                        busy,
    output logic                        overrun
);

    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                        state;
    logic [CNT_W-1:0]              word_cnt;
    logic                          digest_rdy;
    logic [CNT_W-1:0]              idx;
    logic [NUM_WORDS*WORD_W-1:0]   dig_q;
    logic [NUM_WORDS*WORD_W-1:0]   tgt_q;
    logic                          lt_q;
    logic                          gt_q;

    logic [WORD_W-1:0]             dig_words [NUM_WORDS];
    logic [WORD_W-1:0]             tgt_words [NUM_WORDS];
    logic                          word_lt;
    logic                          word_gt;
    logic                          lt_next;
    logic                          gt_next;
    logic                          finish_cmp;

    // Split the captured vectors into addressable words
    generate
        for (genvar i = 0; i < NUM_WORDS; i++) begin : g_words
            assign dig_words[i] = dig_q[i*WORD_W +: WORD_W];
            assign tgt_words[i] = tgt_q[i*WORD_W +: WORD_W];
        end
    endgenerate

    // Track upstream fill level; flag the cycle in which the full digest is present
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_cnt   <= '0;
            digest_rdy <= 1'b0;
        end else begin
            if (shift_enable) begin
                word_cnt <= (word_cnt == LAST_IDX) ? '0 : word_cnt + CNT_W'(1);
            end
            digest_rdy <= shift_enable && (word_cnt == LAST_IDX);
        end
    end

    // Per-word unsigned compare; the first differing word locks the decision
    always_comb begin
        word_lt = dig_words[idx] < tgt_words[idx];
        word_gt = dig_words[idx] > tgt_words[idx];
        lt_next = lt_q | (~gt_q & word_lt);
        gt_next = gt_q | (~lt_q & word_gt);
`ifdef HASH_CMP_EARLY_EXIT_EN
        finish_cmp = (idx == '0) | lt_next | gt_next;
`else
        finish_cmp = (idx == '0);
`endif
    end

    // Capture / compare / report state machine with registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            idx          <= '0;
            dig_q        <= '0;
            tgt_q        <= '0;
            lt_q         <= 1'b0;
            gt_q         <= 1'b0;
            result_valid <= 1'b0;
            hash_found   <= 1'b0;
            found_nonce  <= '0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // A completed digest arriving while occupied is dropped
            overrun <= digest_rdy && (state != IDLE);
            case (state)
                IDLE: begin
                    if (digest_rdy) begin
                        dig_q       <= parallel_in;
                        tgt_q       <= target;
                        found_nonce <= nonce;
                        idx         <= LAST_IDX;
                        lt_q        <= 1'b0;
                        gt_q        <= 1'b0;
                        busy        <= 1'b1;
                        state       <= COMPARE;
                    end
                end
                COMPARE: begin
                    lt_q <= lt_next;
                    gt_q <= gt_next;
                    idx  <= idx - CNT_W'(1);
                    if (finish_cmp) begin
                        // lt or all-equal means digest <= target
                        result_valid <= 1'b1;
                        hash_found   <= ~gt_next;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        hash_found   <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/hash_target_cmp.md
Name: hash_target_cmp

Overview:
- Sits directly downstream of the 8-word serial-to-parallel digest shift register in sha_output.
- Watches the same shift_enable strobe that drives that register. Once 8 words have been shifted in, it captures the 256-bit digest together with the current difficulty target and nonce.
- Compares digest against target one 32-bit word per cycle, most significant word first.
- Reports hash_found (digest <= target) and the winning nonce through a valid/ready handshake to the miner control logic.

Parameters:
- NUM_WORDS, 8, number of 32-bit words per digest. The counter width is derived as clog2(NUM_WORDS).
- WORD_W, 32, width of each compared word.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- n_rst  in  1  asynchronous active-low reset
- shift_enable  in  1  same strobe that shifts the upstream serial-to-parallel register
- parallel_in  in  NUM_WORDS*WORD_W  digest from the upstream parallel_out; word NUM_WORDS-1 (bits 255:224) is the first word shifted in and the most significant
- target  in  NUM_WORDS*WORD_W  difficulty target, same word ordering
- nonce  in  32  nonce associated with the digest currently being shifted
- result_ready  in  1  consumer accepts the result
- result_valid  out  1  result available
- hash_found  out  1  1 = captured digest <= captured target; valid only while result_valid
- found_nonce  out  32  nonce latched with the digest
- busy  out  1  state != IDLE
- overrun  out  1  one-cycle pulse when a completed digest is dropped

Behaviour:
- Reset (async, n_rst=0) clears everything immediately:
  - word_cnt=0, digest_rdy=0, state=IDLE.
  - All outputs 0; captured digest, target and nonce registers 0.
  - Reset mid-compare or while in DONE aborts silently; no overrun pulse.
- Word counter:
  - Increments on every edge with shift_enable=1, in every state.
  - Wraps from NUM_WORDS-1 to 0.
  - The edge with shift_enable=1 and word_cnt==NUM_WORDS-1 sets digest_rdy=1 for exactly the next cycle. During that cycle the upstream parallel_out holds the full digest.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - If digest_rdy=1: latch parallel_in, target and nonce (found_nonce <= nonce), set idx=NUM_WORDS-1, clear the lt/gt flags, go to COMPARE.
  - busy rises on the same edge.
- COMPARE, one word per cycle at idx:
  - If no decision is made yet: hash word < target word sets lt; hash word > target word sets gt; equal words change nothing.
  - Once lt or gt is set, later words are ignored.
  - idx decrements. After the idx=0 edge go to DONE with result_valid=1 and hash_found = lt OR (neither lt nor gt, i.e. all words equal).
  - Comparison is unsigned.
- DONE:
  - result_valid and hash_found are held stable until the edge where result_ready=1.
  - On that edge: result_valid=0, hash_found=0, next state IDLE.
  - result_ready is ignored outside DONE.
- Latency (no early exit): last shift edge E; capture at E+1; compare edges E+2..E+NUM_WORDS+1; result_valid=1 from edge E+NUM_WORDS+1 (E+9 for defaults).
- Overrun: if digest_rdy=1 in any state other than IDLE, that digest is dropped and overrun=1 for one cycle. The counter is unaffected. There is no capture in DONE, even when result_ready=1 in the same cycle.
- No back-pressure is applied upstream; the block never stalls shift_enable.

Optional Feature:
- Macro HASH_CMP_EARLY_EXIT_EN.
- Defined: COMPARE moves to DONE on the edge where lt or gt is first decided (or after idx=0 if all words are equal). Latency ranges from 1 to NUM_WORDS compare cycles.
- Not defined: always exactly NUM_WORDS compare cycles, giving a deterministic latency.
- hash_found results are identical in both builds.

Test Plan:
1. Reset mid-compare: assert n_rst=0 during COMPARE -> all outputs 0 immediately; after release and 7 shifts there is no result_valid.
2. Digest all 0x00000000, target all 0xFFFFFFFF, nonce 0x12345678 -> result_valid at E+9, hash_found=1, found_nonce=0x12345678. Hold result_ready=0 for 5 cycles -> outputs stable. Then result_ready=1 -> result_valid=0 next edge, busy=0.
3. Digest top word 0x00000001, rest 0, target top word 0x00000000, rest all 0xFFFFFFFF -> hash_found=0. Decision comes from word 7. With HASH_CMP_EARLY_EXIT_EN, result_valid at E+2.
4. Digest == target == alternating 0xAAAAAAAA/0x55555555 words -> hash_found=1 (equality counts as found).
5. Shift 16 words back-to-back with result_ready=0 -> first digest captured; second completion gives a one-cycle overrun pulse at E2+1; the first result is unchanged.
6. Shift 3 words, idle 10 cycles with shift_enable=0, shift 5 more -> digest_rdy only after the 8th shift; single result produced.
